// File: rtl/fu_pipe_complex.sv
`default_nettype none
// ============================================================================
// Module   : fu_pipe_complex
// Brief    : Pipelined multiply functional unit with branch-mask squash,
//            mask clearing on correct prediction and saturating squash count.
// Revision : 1.0 - initial release
// ============================================================================
module fu_pipe_complex #(
    parameter int DATA_W          = 32,
    parameter int CHECKPOINTS     = 4,
    parameter int CHECKPOINTS_LOG = 2,
    parameter int TAG_W           = 20,
    parameter int LATENCY         = 3,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inValid_i,
    output logic                       inReady_o,
    input  logic [CHECKPOINTS-1:0]     inBranchMask_i,
    input  logic [TAG_W-1:0]           inTag_i,
    input  logic [1:0]                 opcode_i,
    input  logic [DATA_W-1:0]          data1_i,
    input  logic [DATA_W-1:0]          data2_i,
    input  logic                       ctrlVerified_i,
    input  logic                       ctrlMispredict_i,
    input  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i,
    output logic                       outValid_o,
    input  logic                       outReady_i,
    output logic [CHECKPOINTS-1:0]     outBranchMask_o,
    output logic [TAG_W-1:0]           outTag_o,
    output logic [DATA_W-1:0]          outResult_o,
    output logic [1:0]                 outFlags_o,
    output logic [CNT_W-1:0]           squashCount_o
);

    // Wide enough for LATENCY (max 8) stage kills plus one dropped input
    localparam int c_SUM_W = 4;

    logic [LATENCY-1:0]                  r_valid;
    logic [LATENCY-1:0][CHECKPOINTS-1:0] r_mask;
    logic [LATENCY-1:0][TAG_W-1:0]       r_tag;
    logic [LATENCY-1:0][DATA_W-1:0]      r_result;
    logic [LATENCY-1:0][1:0]             r_flags;
    logic [CNT_W-1:0]                    r_squashCount;

    logic                   w_squash;
    logic                   w_verifyOk;
    logic                   w_stall;
    logic                   w_inDrop;
    logic                   w_accept;
    logic [CHECKPOINTS-1:0] w_smtOneHot;
    logic [CHECKPOINTS-1:0] w_clearMask;
    logic [LATENCY-1:0]     w_kill;
    logic [2*DATA_W-1:0]    w_prodU;
    logic [2*DATA_W-1:0]    w_prodS;
    logic [DATA_W-1:0]      w_result;
    logic [1:0]             w_flags;
    logic [c_SUM_W-1:0]     w_killCount;
    logic [CNT_W:0]         w_cntSum;
    logic [CNT_W-1:0]       w_cntNext;

    assign w_squash    = ctrlVerified_i & ctrlMispredict_i;
    assign w_verifyOk  = ctrlVerified_i & ~ctrlMispredict_i;
    assign w_smtOneHot = CHECKPOINTS'(1) << ctrlSMTid_i;
    assign w_clearMask = w_verifyOk ? w_smtOneHot : '0;

    assign w_stall   = r_valid[LATENCY-1] & ~outReady_i;
    assign inReady_o = ~w_stall;
    assign w_inDrop  = inValid_i & w_squash & inBranchMask_i[ctrlSMTid_i];
    assign w_accept  = inValid_i & ~w_stall & ~w_inDrop;

    generate
        for (genvar i = 0; i < LATENCY; i++) begin : g_kill
            assign w_kill[i] = r_valid[i] & w_squash & r_mask[i][ctrlSMTid_i];
        end
    endgenerate

    // Sign-extending to 2*DATA_W lets one multiplier shape serve MULH
    assign w_prodU = {{DATA_W{1'b0}}, data1_i} * {{DATA_W{1'b0}}, data2_i};
    assign w_prodS = $signed({{DATA_W{data1_i[DATA_W-1]}}, data1_i}) *
                     $signed({{DATA_W{data2_i[DATA_W-1]}}, data2_i});

    always_comb begin
        w_result = '0;
        w_flags  = 2'b00;
        case (opcode_i)
            2'd0:    w_result = w_prodU[DATA_W-1:0];
            2'd1:    w_result = w_prodU[2*DATA_W-1:DATA_W];
            2'd2:    w_result = w_prodS[2*DATA_W-1:DATA_W];
            default: w_flags[1] = 1'b1;
        endcase
        w_flags[0] = (w_result == '0);
    end

    always_comb begin
        w_killCount = c_SUM_W'(w_inDrop & ~w_stall);
        for (int i = 0; i < LATENCY; i++) begin
            w_killCount = w_killCount + c_SUM_W'(w_kill[i]);
        end
    end

    assign w_cntSum  = {1'b0, r_squashCount} + (CNT_W+1)'(w_killCount);
    assign w_cntNext = w_cntSum[CNT_W] ? '1 : w_cntSum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid       <= '0;
            r_mask        <= '0;
            r_tag         <= '0;
            r_result      <= '0;
            r_flags       <= '0;
            r_squashCount <= '0;
        end else begin
            if (w_stall) begin
                // Held entries still see squash and mask clearing
                for (int i = 0; i < LATENCY; i++) begin
                    r_valid[i] <= r_valid[i] & ~w_kill[i];
                    r_mask[i]  <= r_mask[i] & ~w_clearMask;
                end
            end else begin
                r_valid[0]  <= w_accept;
                r_mask[0]   <= inBranchMask_i & ~w_clearMask;
                r_tag[0]    <= inTag_i;
                r_result[0] <= w_result;
                r_flags[0]  <= w_flags;
                for (int i = 1; i < LATENCY; i++) begin
                    r_valid[i]  <= r_valid[i-1] & ~w_kill[i-1];
                    r_mask[i]   <= r_mask[i-1] & ~w_clearMask;
                    r_tag[i]    <= r_tag[i-1];
                    r_result[i] <= r_result[i-1];
                    r_flags[i]  <= r_flags[i-1];
                end
            end
            r_squashCount <= w_cntNext;
        end
    end

    assign outValid_o      = r_valid[LATENCY-1] &
                             ~(w_squash & r_mask[LATENCY-1][ctrlSMTid_i]);
    assign outBranchMask_o = r_mask[LATENCY-1];
    assign outTag_o        = r_tag[LATENCY-1];
    assign outResult_o     = r_result[LATENCY-1];
    assign outFlags_o      = r_flags[LATENCY-1];
    assign squashCount_o   = r_squashCount;

endmodule
`default_nettype wire

// File: tb/tb_fu_pipe_complex.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_pipe_complex
// Brief    : Directed self-checking bench for fu_pipe_complex (LATENCY=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_pipe_complex;

    localparam int DW = 32;
    localparam int CP = 4;
    localparam int CPL = 2;
    localparam int TW = 20;
    localparam int LAT = 3;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           inValid;
    logic           inReady;
    logic [CP-1:0]  inBranchMask;
    logic [TW-1:0]  inTag;
    logic [1:0]     opcode;
    logic [DW-1:0]  data1;
    logic [DW-1:0]  data2;
    logic           ctrlVerified;
    logic           ctrlMispredict;
    logic [CPL-1:0] ctrlSMTid;
    logic           outValid;
    logic           outReady;
    logic [CP-1:0]  outBranchMask;
    logic [TW-1:0]  outTag;
    logic [DW-1:0]  outResult;
    logic [1:0]     outFlags;
    logic [CW-1:0]  squashCount;

    int nChecks = 0;
    int nPassed = 0;

    fu_pipe_complex #(
        .DATA_W(DW), .CHECKPOINTS(CP), .CHECKPOINTS_LOG(CPL),
        .TAG_W(TW), .LATENCY(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .inValid_i(inValid), .inReady_o(inReady),
        .inBranchMask_i(inBranchMask), .inTag_i(inTag), .opcode_i(opcode),
        .data1_i(data1), .data2_i(data2),
        .ctrlVerified_i(ctrlVerified), .ctrlMispredict_i(ctrlMispredict),
        .ctrlSMTid_i(ctrlSMTid),
        .outValid_o(outValid), .outReady_i(outReady),
        .outBranchMask_o(outBranchMask), .outTag_o(outTag),
        .outResult_o(outResult), .outFlags_o(outFlags),
        .squashCount_o(squashCount)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPassed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inValid = 1'b0; inBranchMask = '0; inTag = '0; opcode = 2'd0;
        data1 = '0; data2 = '0;
        ctrlVerified = 1'b0; ctrlMispredict = 1'b0; ctrlSMTid = '0;
    endtask

    task automatic drive(input logic [CP-1:0] m, input logic [TW-1:0] t, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        inValid = 1'b1; inBranchMask = m; inTag = t; opcode = op; data1 = a; data2 = b;
        ctrlVerified = 1'b0; ctrlMispredict = 1'b0; ctrlSMTid = '0;
    endtask

    task automatic squashNow(input logic [CPL-1:0] id);
        ctrlVerified = 1'b1; ctrlMispredict = 1'b1; ctrlSMTid = id;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;
        logic [DW-1:0] got[$];
        int pend[$];

        reset = 1'b0; outReady = 1'b1; idle();
        #12;
        checkValue("rst_outValid", outValid, 0);
        checkValue("rst_inReady", inReady, 1);
        checkValue("rst_squashCount", squashCount, 0);
        checkValue("rst_outResult", outResult, 0);
        checkValue("rst_outMask", outBranchMask, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic MUL latency
        drive(4'b0000, 20'h5, 2'd0, 32'd7, 32'd6);
        #1 checkValue("mul_inReady", inReady, 1);
        tick(); idle();
        lat = 1;
        while (!outValid && lat < 10) begin tick(); lat++; end
        checkValue("mul_latency", lat, 3);
        checkValue("mul_result", outResult, 42);
        checkValue("mul_flags", outFlags, 2'b00);
        checkValue("mul_tag", outTag, 20'h5);
        tick();

        // MULH / MULHU / illegal back-to-back
        drive(4'b0000, 20'h1, 2'd2, 32'hFFFF_FFFF, 32'd2); tick();
        drive(4'b0000, 20'h2, 2'd1, 32'hFFFF_FFFF, 32'd2); tick();
        drive(4'b0000, 20'h3, 2'd3, 32'd5, 32'd5);         tick();
        idle();
        checkValue("mulh_valid", outValid, 1);
        checkValue("mulh_tag", outTag, 20'h1);
        checkValue("mulh_result", outResult, 32'hFFFF_FFFF);
        checkValue("mulh_flags", outFlags, 2'b00);
        tick();
        checkValue("mulhu_result", outResult, 32'd1);
        checkValue("mulhu_tag", outTag, 20'h2);
        tick();
        checkValue("illegal_result", outResult, 32'd0);
        checkValue("illegal_flags", outFlags, 2'b11);
        tick();

        // Backpressure: four inputs, outReady held low then released
        pend = '{1, 2, 3, 4};
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            outReady = (c >= 6);
            if (pend.size() > 0) drive(4'b0000, TW'(16 + pend[0]), 2'd0, DW'(pend[0]), 32'd10);
            else idle();
            #1;
            if (c == 3) checkValue("bp_inReady_low", inReady, 0);
            if (c == 5) begin
                checkValue("bp_head_valid", outValid, 1);
                checkValue("bp_head_result", outResult, 10);
            end
            if (outValid && outReady) got.push_back(outResult);
            if (inValid && inReady) void'(pend.pop_front());
            tick();
        end
        idle(); outReady = 1'b1;
        checkValue("bp_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) checkValue("bp_order", got[i], 64'(10 * (i + 1)));
        tick();

        // Squash while stalled frees the output slot
        outReady = 1'b0;
        drive(4'b0100, 20'h7, 2'd0, 32'd3, 32'd3); tick(); idle(); tick(); tick();
        checkValue("ss_stalled", inReady, 0);
        squashNow(2'd2);
        #1;
        checkValue("ss_outValid_filtered", outValid, 0);
        tick(); idle();
        checkValue("ss_inReady_freed", inReady, 1);
        checkValue("ss_outValid", outValid, 0);
        checkValue("ss_count", squashCount, 1);
        outReady = 1'b1;
        tick();

        // Three in flight, squash SMTid 0
        drive(4'b0001, 20'hA, 2'd0, 32'd1, 32'd1); tick();
        drive(4'b0010, 20'hB, 2'd0, 32'd2, 32'd3); tick();
        drive(4'b0001, 20'hC, 2'd0, 32'd4, 32'd5); tick();
        idle(); squashNow(2'd0);
        #1;
        checkValue("sq_head_filtered", outValid, 0);
        tick(); idle();
        checkValue("sq_b_valid", outValid, 1);
        checkValue("sq_b_tag", outTag, 20'hB);
        checkValue("sq_b_mask", outBranchMask, 4'b0010);
        checkValue("sq_b_result", outResult, 6);
        checkValue("sq_count", squashCount, 3);
        tick();
        checkValue("sq_c_gone", outValid, 0);
        tick();

        // Input dropped by coincident squash
        drive(4'b0100, 20'hD, 2'd0, 32'd9, 32'd9); squashNow(2'd2);
        #1 checkValue("drop_inReady", inReady, 1);
        tick(); idle();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin seen |= outValid; tick(); end
        checkValue("drop_no_output", seen, 0);
        checkValue("drop_count", squashCount, 4);

        // Correct-prediction verify clears mask bit in stage and at capture
        drive(4'b0011, 20'hE, 2'd0, 32'd2, 32'd2); tick();
        drive(4'b0011, 20'hF, 2'd0, 32'd3, 32'd3);
        ctrlVerified = 1'b1; ctrlMispredict = 1'b0; ctrlSMTid = 2'd1;
        tick(); idle(); tick();
        checkValue("vf_e_valid", outValid, 1);
        checkValue("vf_e_mask", outBranchMask, 4'b0001);
        checkValue("vf_e_tag", outTag, 20'hE);
        tick();
        checkValue("vf_f_mask", outBranchMask, 4'b0001);
        checkValue("vf_f_result", outResult, 9);
        tick();

        // Reset mid-operation
        drive(4'b0000, 20'h11, 2'd0, 32'd1, 32'd1); tick();
        drive(4'b0000, 20'h12, 2'd0, 32'd1, 32'd1); tick();
        idle(); tick();
        checkValue("mr_pre_valid", outValid, 1);
        checkValue("mr_pre_count", squashCount, 4);
        reset = 1'b0;
        #1;
        checkValue("mr_outValid", outValid, 0);
        checkValue("mr_count", squashCount, 0);
        checkValue("mr_inReady", inReady, 1);
        tick(); tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); seen |= outValid; end
        checkValue("mr_no_output", seen, 0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
